writeback_hilo: RTL

Final pipeline stage downstream of the execute-stage control unit. It registers each accepted EX instruction into the WB stage and drives the register-file write port. It owns the HI/LO registers and the GPIO output register. HI/LO are loaded by an iterative 32-cycle shift-add multiplier, and `stall_EX` holds the upstream stages while a multiply runs.

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/seq_multiplier.sv | 112 +++++++++++
 rtl/writeback_hilo.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Types and constants shared by the writeback stage and its sequential
// multiplier.
//   regsel_t    : writeback source select (ALU / HI / LO; code 3 acts as ALU)
//   mul_state_t : multiplier FSM states
//   DATA_W      : datapath width
//   RADDR_W     : register-file address width
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [1:0] {
        RS_ALU = 2'd0,
        RS_HI  = 2'd1,
        RS_LO  = 2'd2
    } regsel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2
    } mul_state_t;

endpackage : pipeline_pkg

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier. Signed operands are reduced to magnitudes,
// multiplied unsigned over WIDTH cycles, and the sign is restored in a final
// FIX cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start_i    : begin a multiply (honoured only in IDLE)
//   signed_i   : 1 = signed operands, 0 = unsigned
//   a_i, b_i   : operands
//   busy_o     : high in MUL and FIX
//   done_o     : high during FIX; product_o is valid in that cycle
//   product_o  : 2*WIDTH-bit result
// -----------------------------------------------------------------------------
module seq_multiplier
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_t           state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 neg_q, neg_d;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // Negating the most negative value wraps to itself, which is exactly its
    // magnitude when read as unsigned.
    assign a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        neg_d    = neg_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = MUL;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    count_d  = '0;
                    neg_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == FIX);
    assign product_o = neg_q ? -acc_q : acc_q;

endmodule : seq_multiplier

// File: rtl/writeback_hilo.sv
// -----------------------------------------------------------------------------
// writeback_hilo
// Writeback stage: registers each accepted EX instruction and drives the
// register-file write port, owns HI/LO (loaded by the sequential multiplier)
// and the GPIO output register. stall_EX holds upstream while a multiply runs.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   valid_EX          : instruction present in EX
//   regwrite_EX       : instruction writes a GPR
//   regsel_EX         : writeback source (0 ALU, 1 HI, 2 LO, 3 ALU)
//   enhilo_EX         : start a multiply
//   mult_signed_EX    : 1 = mult, 0 = multu
//   A_EX, B_EX        : multiply operands
//   alu_result_EX     : ALU result
//   writeaddr_EX      : destination register
//   gpio_we_EX        : GPIO write enable
//   gpio_data_EX      : GPIO write data
//   regwrite_WB       : register-file write enable
//   writeaddr_WB      : register-file write address
//   writedata_WB      : register-file write data
//   hi_out, lo_out    : HI/LO contents
//   stall_EX          : multiplier busy
//   gpio_out          : GPIO output register
// -----------------------------------------------------------------------------
module writeback_hilo #(
    parameter int WIDTH   = pipeline_pkg::DATA_W,
    parameter int RADDR_W = pipeline_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_EX,
    input  logic               regwrite_EX,
    input  logic [1:0]         regsel_EX,
    input  logic               enhilo_EX,
    input  logic               mult_signed_EX,
    input  logic [WIDTH-1:0]   A_EX,
    input  logic [WIDTH-1:0]   B_EX,
    input  logic [WIDTH-1:0]   alu_result_EX,
    input  logic [RADDR_W-1:0] writeaddr_EX,
    input  logic               gpio_we_EX,
    input  logic [WIDTH-1:0]   gpio_data_EX,
    output logic               regwrite_WB,
    output logic [RADDR_W-1:0] writeaddr_WB,
    output logic [WIDTH-1:0]   writedata_WB,
    output logic [WIDTH-1:0]   hi_out,
    output logic [WIDTH-1:0]   lo_out,
    output logic               stall_EX,
    output logic [WIDTH-1:0]   gpio_out
);

    logic                 accept;
    logic                 mul_busy;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    logic                 regwrite_q, regwrite_d;
    logic [RADDR_W-1:0]   writeaddr_q;
    logic [WIDTH-1:0]     writedata_q, writedata_d;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic [WIDTH-1:0]     gpio_q;

    // Nothing in EX is taken while the multiplier is busy; the instruction
    // stays held upstream until stall_EX falls.
    assign accept = valid_EX & ~stall_EX;

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (accept & enhilo_EX),
        .signed_i  (mult_signed_EX),
        .a_i       (A_EX),
        .b_i       (B_EX),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Writes to $0 are dropped here so the register file never sees them.
    assign regwrite_d = accept & regwrite_EX & (writeaddr_EX != '0);

    always_comb begin
        writedata_d = alu_result_EX;
        case (pipeline_pkg::regsel_t'(regsel_EX))
            pipeline_pkg::RS_HI: writedata_d = hi_q;
            pipeline_pkg::RS_LO: writedata_d = lo_q;
            default:             writedata_d = alu_result_EX;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            writeaddr_q <= '0;
            writedata_q <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            gpio_q      <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            regwrite_q <= regwrite_d;
            if (accept) begin
                writeaddr_q <= writeaddr_EX;
                writedata_q <= writedata_d;
                if (gpio_we_EX) begin
                    gpio_q <= gpio_data_EX;
                end
            end
            if (mul_done) begin
                {hi_q, lo_q} <= mul_product;
            end
        end
    end

    assign regwrite_WB  = regwrite_q;
    assign writeaddr_WB = writeaddr_q;
    assign writedata_WB = writedata_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;
    assign gpio_out     = gpio_q;
    assign stall_EX     = mul_busy;

endmodule : writeback_hilo
